// File: rtl/card_pkg.sv
// Shared mode encodings, ROM word layout and card indices for the card decode pipeline.
package card_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [1:0] {
    MODE_IDLE    = 2'd0,
    MODE_ACTION  = 2'd1,
    MODE_BUY     = 2'd2,
    MODE_ENDGAME = 2'd3
  } mode_t;

  localparam int unsigned BUY_W    = 3;
  localparam int unsigned ACTION_W = 3;
  localparam int unsigned DRAW_W   = 3;
  localparam int unsigned GOLD_W   = 5;
  localparam int unsigned VP_W     = 4;
  localparam int unsigned COST_W   = 4;
  localparam int unsigned NAME_W   = 8;
  localparam int unsigned WORD_W   = 30;

  localparam int unsigned NAME_LSB   = 0;
  localparam int unsigned COST_LSB   = 8;
  localparam int unsigned VP_LSB     = 12;
  localparam int unsigned GOLD_LSB   = 16;
  localparam int unsigned DRAW_LSB   = 21;
  localparam int unsigned ACTION_LSB = 24;
  localparam int unsigned BUY_LSB    = 27;

  // Field order mirrors the LSB table above, MSB first.
  typedef struct packed {
    logic [BUY_W-1:0]    buy;
    logic [ACTION_W-1:0] action;
    logic [DRAW_W-1:0]   draw;
    logic [GOLD_W-1:0]   gold;
    logic [VP_W-1:0]     vp;
    logic [COST_W-1:0]   cost;
    logic [NAME_W-1:0]   name;
  } card_word_t;

  localparam int unsigned CARD_COPPER   = 0;
  localparam int unsigned CARD_SILVER   = 1;
  localparam int unsigned CARD_GOLD     = 2;
  localparam int unsigned CARD_ESTATE   = 3;
  localparam int unsigned CARD_DUCHY    = 4;
  localparam int unsigned CARD_PROVINCE = 5;
  localparam int unsigned CARD_VILLAGE  = 6;
  localparam int unsigned CARD_MARKET   = 7;

  // Codes 4-7 are treated as IDLE.
  function automatic mode_t decode_mode(input logic [MODE_W-1:0] m);
    mode_t r;
    case (m)
      3'd1:    r = MODE_ACTION;
      3'd2:    r = MODE_BUY;
      3'd3:    r = MODE_ENDGAME;
      default: r = MODE_IDLE;
    endcase
    return r;
  endfunction

  function automatic card_word_t make_card(
    input logic [BUY_W-1:0]    buy,
    input logic [ACTION_W-1:0] action,
    input logic [DRAW_W-1:0]   draw,
    input logic [GOLD_W-1:0]   gold,
    input logic [VP_W-1:0]     vp,
    input logic [COST_W-1:0]   cost
  );
    logic [WORD_W-1:0] w;
    w = '0;
    w[BUY_LSB    +: BUY_W]    = buy;
    w[ACTION_LSB +: ACTION_W] = action;
    w[DRAW_LSB   +: DRAW_W]   = draw;
    w[GOLD_LSB   +: GOLD_W]   = gold;
    w[VP_LSB     +: VP_W]     = vp;
    w[COST_LSB   +: COST_W]   = cost;
    w[NAME_LSB   +: NAME_W]   = '0;
    return card_word_t'(w);
  endfunction

endpackage

// File: rtl/card_rom.sv
// Fixed card attribute table with a registered read port.
module card_rom
  import card_pkg::*;
#(
  parameter int unsigned CARD_W = 4
) (
  input  logic              clk,
  input  logic [CARD_W-1:0] addr,
  output card_word_t        word
);

  card_word_t rom_c;

  always_comb begin
    rom_c = '0;
    case (addr)
      CARD_W'(CARD_COPPER):   rom_c = make_card(3'd0, 3'd0, 3'd0, 5'd1, 4'd0, 4'd0);
      CARD_W'(CARD_SILVER):   rom_c = make_card(3'd0, 3'd0, 3'd0, 5'd2, 4'd0, 4'd3);
      CARD_W'(CARD_GOLD):     rom_c = make_card(3'd0, 3'd0, 3'd0, 5'd3, 4'd0, 4'd6);
      CARD_W'(CARD_ESTATE):   rom_c = make_card(3'd0, 3'd0, 3'd0, 5'd0, 4'd1, 4'd2);
      CARD_W'(CARD_DUCHY):    rom_c = make_card(3'd0, 3'd0, 3'd0, 5'd0, 4'd3, 4'd5);
      CARD_W'(CARD_PROVINCE): rom_c = make_card(3'd0, 3'd0, 3'd0, 5'd0, 4'd6, 4'd8);
      CARD_W'(CARD_VILLAGE):  rom_c = make_card(3'd0, 3'd2, 3'd1, 5'd0, 4'd0, 4'd3);
      CARD_W'(CARD_MARKET):   rom_c = make_card(3'd1, 3'd1, 3'd1, 5'd1, 4'd0, 4'd5);
      default:                rom_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    word <= rom_c;
  end

endmodule

// File: rtl/card_decode_pipe.sv
// Card decode pipeline: input FIFO, ROM lookup stage and output stage with
// per-mode saturating running totals.
module card_decode_pipe
  import card_pkg::*;
#(
  parameter int unsigned CARD_W = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ACC_W  = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MODE_W-1:0]   mode,
  input  logic [CARD_W-1:0]   card_stream,
  input  logic                card_valid,
  output logic                card_ready,
  input  logic [GOLD_W-1:0]   gold_in_bank,
  input  logic                clear,
  output logic                nextcard,
  output logic [BUY_W-1:0]    obuy,
  output logic [ACTION_W-1:0] oaction,
  output logic [DRAW_W-1:0]   odraw,
  output logic [GOLD_W-1:0]   ogold,
  output logic [NAME_W-1:0]   oname,
  output logic                can_buy,
  output logic                reject,
  output logic [ACC_W-1:0]    tot_buy,
  output logic [ACC_W-1:0]    tot_action,
  output logic [ACC_W-1:0]    tot_draw,
  output logic [ACC_W-1:0]    tot_gold,
  output logic [ACC_W-1:0]    tot_spent,
  output logic [ACC_W-1:0]    tot_vp,
  output logic                busy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    return s[ACC_W] ? ACC_MAX : s[ACC_W-1:0];
  endfunction

  // ---------------- input FIFO ----------------
  logic [CARD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              push_c;
  logic              pop_c;

  // The output path never stalls, so the head leaves whenever one is present.
  always_comb begin
    push_c     = card_valid & card_ready;
    pop_c      = (count != '0);
    count_next = count + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= card_stream;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      card_ready <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count      <= count_next;
      card_ready <= (count_next != CNT_W'(DEPTH));
    end
  end

  // ---------------- ROM stage ----------------
  card_word_t rom_word;
  logic       s1_valid;
  mode_t      s1_mode;

  card_rom #(
    .CARD_W(CARD_W)
  ) u_rom (
    .clk (clk),
    .addr(mem[rd_ptr]),
    .word(rom_word)
  );

  // Mode is captured as the card leaves the FIFO and rides along with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_IDLE;
    end else begin
      s1_valid <= pop_c;
      if (pop_c) begin
        s1_mode <= decode_mode(mode);
      end
    end
  end

  // ---------------- output stage ----------------
  logic [SUM_W-1:0] need_c;
  logic             afford_c;
  logic             is_buy_c;
  logic [ACC_W-1:0] tot_buy_c;
  logic [ACC_W-1:0] tot_action_c;
  logic [ACC_W-1:0] tot_draw_c;
  logic [ACC_W-1:0] tot_gold_c;
  logic [ACC_W-1:0] tot_spent_c;
  logic [ACC_W-1:0] tot_vp_c;

  always_comb begin
    need_c       = SUM_W'(tot_spent) + SUM_W'(rom_word.cost);
    afford_c     = (SUM_W'(gold_in_bank) >= need_c);
    is_buy_c     = s1_valid && (s1_mode == MODE_BUY);
    tot_buy_c    = tot_buy;
    tot_action_c = tot_action;
    tot_draw_c   = tot_draw;
    tot_gold_c   = tot_gold;
    tot_spent_c  = tot_spent;
    tot_vp_c     = tot_vp;
    // clear overrides any contribution from the card finishing this cycle
    if (clear) begin
      tot_buy_c    = '0;
      tot_action_c = '0;
      tot_draw_c   = '0;
      tot_gold_c   = '0;
      tot_spent_c  = '0;
      tot_vp_c     = '0;
    end else if (s1_valid) begin
      case (s1_mode)
        MODE_ACTION: begin
          tot_buy_c    = sat_add(tot_buy,    ACC_W'(rom_word.buy));
          tot_action_c = sat_add(tot_action, ACC_W'(rom_word.action));
          tot_draw_c   = sat_add(tot_draw,   ACC_W'(rom_word.draw));
          tot_gold_c   = sat_add(tot_gold,   ACC_W'(rom_word.gold));
        end
        MODE_BUY: begin
          if (afford_c) begin
            tot_spent_c = sat_add(tot_spent, ACC_W'(rom_word.cost));
          end
        end
        MODE_ENDGAME: begin
          tot_vp_c = sat_add(tot_vp, ACC_W'(rom_word.vp));
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nextcard   <= 1'b0;
      obuy       <= '0;
      oaction    <= '0;
      odraw      <= '0;
      ogold      <= '0;
      oname      <= '0;
      can_buy    <= 1'b0;
      reject     <= 1'b0;
      tot_buy    <= '0;
      tot_action <= '0;
      tot_draw   <= '0;
      tot_gold   <= '0;
      tot_spent  <= '0;
      tot_vp     <= '0;
      busy       <= 1'b0;
    end else begin
      nextcard   <= s1_valid;
      obuy       <= s1_valid ? rom_word.buy    : '0;
      oaction    <= s1_valid ? rom_word.action : '0;
      odraw      <= s1_valid ? rom_word.draw   : '0;
      oname      <= s1_valid ? rom_word.name   : '0;
      ogold      <= !s1_valid ? '0 :
                    (s1_mode == MODE_ENDGAME) ? GOLD_W'(rom_word.vp) : rom_word.gold;
      can_buy    <= is_buy_c & afford_c;
      reject     <= is_buy_c & ~afford_c;
      tot_buy    <= tot_buy_c;
      tot_action <= tot_action_c;
      tot_draw   <= tot_draw_c;
      tot_gold   <= tot_gold_c;
      tot_spent  <= tot_spent_c;
      tot_vp     <= tot_vp_c;
      // Reflects the state after this edge: FIFO, ROM stage or output stage occupied.
      busy       <= (count_next != '0) | pop_c | s1_valid;
    end
  end

endmodule

// File: tb/tb_card_decode_pipe.sv
// Self-checking bench for card_decode_pipe: queue-level reference model plus directed scenarios.
module tb_card_decode_pipe;

  localparam int CARD_W = 4;
  localparam int DEPTH  = 4;
  localparam int ACC_W  = 6;
  localparam int MAXV   = (1 << ACC_W) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] mode;
  logic [3:0] card_stream;
  logic       card_valid;
  logic       card_ready;
  logic [4:0] gold_in_bank;
  logic       clear;
  logic       nextcard;
  logic [2:0] obuy, oaction, odraw;
  logic [4:0] ogold;
  logic [7:0] oname;
  logic       can_buy, reject;
  logic [5:0] tot_buy, tot_action, tot_draw, tot_gold, tot_spent, tot_vp;
  logic       busy;

  card_decode_pipe #(
    .CARD_W(CARD_W),
    .DEPTH (DEPTH),
    .ACC_W (ACC_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .card_stream (card_stream),
    .card_valid  (card_valid),
    .card_ready  (card_ready),
    .gold_in_bank(gold_in_bank),
    .clear       (clear),
    .nextcard    (nextcard),
    .obuy        (obuy),
    .oaction     (oaction),
    .odraw       (odraw),
    .ogold       (ogold),
    .oname       (oname),
    .can_buy     (can_buy),
    .reject      (reject),
    .tot_buy     (tot_buy),
    .tot_action  (tot_action),
    .tot_draw    (tot_draw),
    .tot_gold    (tot_gold),
    .tot_spent   (tot_spent),
    .tot_vp      (tot_vp),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_out = 0;

  // Reference model state
  int q[$];
  bit st_valid = 0;
  int st_card = 0;
  int st_mode = 0;
  int e_next = 0, e_buy = 0, e_act = 0, e_draw = 0, e_gold = 0, e_can = 0, e_rej = 0;
  int e_tb = 0, e_ta = 0, e_td = 0, e_tg = 0, e_ts = 0, e_tv = 0;
  int e_ready = 0, e_busy = 0;

  int cap_cyc[$];
  int cap_gold[$];
  int cap_can[$];
  int cap_rej[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void card_info(input int idx, output int b, output int a, output int d,
                                    output int g, output int v, output int c);
    b = 0; a = 0; d = 0; g = 0; v = 0; c = 0;
    case (idx)
      0: g = 1;
      1: begin g = 2; c = 3; end
      2: begin g = 3; c = 6; end
      3: begin v = 1; c = 2; end
      4: begin v = 3; c = 5; end
      5: begin v = 6; c = 8; end
      6: begin a = 2; d = 1; c = 3; end
      7: begin b = 1; a = 1; d = 1; g = 1; c = 5; end
      default: ;
    endcase
  endfunction

  function automatic int sat(input int x);
    return (x > MAXV) ? MAXV : x;
  endfunction

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic tick();
    int b, a, d, g, v, c, m;
    @(posedge clk);
    cyc++;
    if (reset) begin
      q.delete();
      st_valid = 0;
      e_next = 0; e_buy = 0; e_act = 0; e_draw = 0; e_gold = 0; e_can = 0; e_rej = 0;
      e_tb = 0; e_ta = 0; e_td = 0; e_tg = 0; e_ts = 0; e_tv = 0;
      e_ready = 0; e_busy = 0;
    end else begin
      e_next = st_valid ? 1 : 0;
      e_buy = 0; e_act = 0; e_draw = 0; e_gold = 0; e_can = 0; e_rej = 0;
      card_info(st_card, b, a, d, g, v, c);
      if (st_valid) begin
        e_buy = b; e_act = a; e_draw = d;
        e_gold = (st_mode == 3) ? v : g;
        if (st_mode == 2) begin
          e_can = (int'(gold_in_bank) >= e_ts + c) ? 1 : 0;
          e_rej = 1 - e_can;
        end
      end
      if (clear) begin
        e_tb = 0; e_ta = 0; e_td = 0; e_tg = 0; e_ts = 0; e_tv = 0;
      end else if (st_valid) begin
        if (st_mode == 1) begin
          e_tb = sat(e_tb + b); e_ta = sat(e_ta + a); e_td = sat(e_td + d); e_tg = sat(e_tg + g);
        end else if (st_mode == 2 && e_can == 1) begin
          e_ts = sat(e_ts + c);
        end else if (st_mode == 3) begin
          e_tv = sat(e_tv + v);
        end
      end
      st_valid = (q.size() != 0);
      if (st_valid) begin
        st_card = q.pop_front();
        m = int'(mode);
        st_mode = (m > 3) ? 0 : m;
      end
      if (card_valid && e_ready == 1) begin
        q.push_back(int'(card_stream));
        n_acc++;
      end
      e_ready = (q.size() < DEPTH) ? 1 : 0;
      e_busy = (q.size() != 0 || st_valid || e_next == 1) ? 1 : 0;
    end
    @(negedge clk);
    chk("nextcard",   int'(nextcard),   e_next);
    chk("card_ready", int'(card_ready), e_ready);
    chk("busy",       int'(busy),       e_busy);
    chk("can_buy",    int'(can_buy),    e_can);
    chk("reject",     int'(reject),     e_rej);
    chk("tot_buy",    int'(tot_buy),    e_tb);
    chk("tot_action", int'(tot_action), e_ta);
    chk("tot_draw",   int'(tot_draw),   e_td);
    chk("tot_gold",   int'(tot_gold),   e_tg);
    chk("tot_spent",  int'(tot_spent),  e_ts);
    chk("tot_vp",     int'(tot_vp),     e_tv);
    if (e_next == 1) begin
      chk("obuy",    int'(obuy),    e_buy);
      chk("oaction", int'(oaction), e_act);
      chk("odraw",   int'(odraw),   e_draw);
      chk("ogold",   int'(ogold),   e_gold);
      chk("oname",   int'(oname),   0);
    end
    if (nextcard) begin
      n_out++;
      cap_cyc.push_back(cyc);
      cap_gold.push_back(int'(ogold));
      cap_can.push_back(int'(can_buy));
      cap_rej.push_back(int'(reject));
    end
  endtask

  task automatic push_one(input int card);
    card_valid = 1'b1;
    card_stream = 4'(card);
    tick();
  endtask

  task automatic drain();
    card_valid = 1'b0;
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("drain_busy", int'(busy), 0);
  endtask

  task automatic start_phase();
    card_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cap_cyc.delete(); cap_gold.delete(); cap_can.delete(); cap_rej.delete();
    n_acc = 0;
    n_out = 0;
  endtask

  initial begin
    int acc_cyc;
    reset = 1'b1; mode = 3'd0; card_stream = '0; card_valid = 1'b0;
    gold_in_bank = '0; clear = 1'b0;
    tick();
    tick();
    chk("rst_ready", int'(card_ready), 0);
    chk("rst_next",  int'(nextcard),   0);
    chk("rst_busy",  int'(busy),       0);
    chk("rst_vp",    int'(tot_vp),     0);
    reset = 1'b0;
    tick();
    chk("rel_ready", int'(card_ready), 1);

    // ACTION: village, market, copper back-to-back
    mode = 3'd1;
    start_phase();
    push_one(6);
    acc_cyc = cyc;
    push_one(7);
    chk("act_not_yet", int'(nextcard), 0);
    push_one(0);
    chk("act_first", int'(nextcard), 1);
    chk("act_first_action", int'(oaction), 2);
    drain();
    chk("act_count", cap_cyc.size(), 3);
    if (cap_cyc.size() == 3) begin
      chk("act_latency", cap_cyc[0] - acc_cyc, 2);
      chk("act_span", cap_cyc[2] - cap_cyc[0], 2);
    end
    chk("act_tot_action", int'(tot_action), 3);
    chk("act_tot_draw",   int'(tot_draw),   2);
    chk("act_tot_buy",    int'(tot_buy),    1);
    chk("act_tot_gold",   int'(tot_gold),   2);

    // BUY with 8 gold: silver, market, copper accepted, then gold refused
    mode = 3'd2;
    gold_in_bank = 5'd8;
    start_phase();
    push_one(1); push_one(7); push_one(0);
    drain();
    push_one(2);
    drain();
    chk("buy_count", cap_can.size(), 4);
    if (cap_can.size() == 4) begin
      chk("buy0_can", cap_can[0], 1); chk("buy0_rej", cap_rej[0], 0);
      chk("buy1_can", cap_can[1], 1); chk("buy1_rej", cap_rej[1], 0);
      chk("buy2_can", cap_can[2], 1); chk("buy2_rej", cap_rej[2], 0);
      chk("buy3_can", cap_can[3], 0); chk("buy3_rej", cap_rej[3], 1);
    end
    chk("buy_spent", int'(tot_spent), 8);

    // ENDGAME: province, duchy, estate, estate, then saturate
    mode = 3'd3;
    start_phase();
    push_one(5); push_one(4); push_one(3); push_one(3);
    drain();
    chk("end_count", cap_gold.size(), 4);
    if (cap_gold.size() == 4) begin
      chk("end_g0", cap_gold[0], 6);
      chk("end_g1", cap_gold[1], 3);
      chk("end_g2", cap_gold[2], 1);
      chk("end_g3", cap_gold[3], 1);
    end
    chk("end_vp", int'(tot_vp), 11);
    for (int i = 0; i < 10; i++) push_one(5);
    drain();
    chk("end_vp_sat", int'(tot_vp), 63);

    // Continuous valid for DEPTH+2 cycles: nothing lost or duplicated
    mode = 3'd1;
    start_phase();
    for (int i = 0; i < DEPTH + 2; i++) push_one(int'($urandom_range(0, 7)));
    drain();
    chk("stream_in_out", n_out, n_acc);
    chk("stream_idle_next", int'(nextcard), 0);

    // clear on the same edge as a gold ACTION update with tot_gold=5
    mode = 3'd1;
    start_phase();
    push_one(2); push_one(1);
    drain();
    chk("clr_pre_gold", int'(tot_gold), 5);
    push_one(2);
    card_valid = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_next", int'(nextcard), 1);
    chk("clr_ogold", int'(ogold), 3);
    chk("clr_gold", int'(tot_gold), 0);
    drain();

    // reset with cards in flight
    mode = 3'd1;
    start_phase();
    push_one(7); push_one(7); push_one(7);
    card_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("rif_next", int'(nextcard), 0);
    chk("rif_action", int'(tot_action), 0);
    chk("rif_ready", int'(card_ready), 0);
    tick();
    reset = 1'b0;
    n_out = 0;
    tick();
    chk("rif_ready_rel", int'(card_ready), 1);
    for (int i = 0; i < 6; i++) tick();
    chk("rif_no_next", n_out, 0);
    chk("rif_busy", int'(busy), 0);

    // Randomised traffic against the model
    for (int i = 0; i < 2000; i++) begin
      card_valid   = ($urandom_range(0, 3) != 0);
      card_stream  = 4'($urandom_range(0, 15));
      mode         = 3'($urandom_range(0, 7));
      gold_in_bank = 5'($urandom_range(0, 31));
      clear        = ($urandom_range(0, 40) == 0);
      reset        = ($urandom_range(0, 300) == 0);
      tick();
    end
    reset = 1'b0;
    clear = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
